// File: rtl/cpu_mdu_issue_pkg.sv
// Shared definitions for the MDU issue block.
// Op codes follow the M-extension funct3 encoding.
package cpu_mdu_issue_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] MDU_MUL    = 3'd0;
  localparam logic [2:0] MDU_MULH   = 3'd1;
  localparam logic [2:0] MDU_MULHSU = 3'd2;
  localparam logic [2:0] MDU_MULHU  = 3'd3;
  localparam logic [2:0] MDU_DIV    = 3'd4;
  localparam logic [2:0] MDU_DIVU   = 3'd5;
  localparam logic [2:0] MDU_REM    = 3'd6;
  localparam logic [2:0] MDU_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    DONE
  } state_e;

  function automatic logic is_mulh(input logic [2:0] c);
    return (c == MDU_MULH) || (c == MDU_MULHSU) || (c == MDU_MULHU);
  endfunction

  function automatic logic is_unsigned_div(input logic [2:0] c);
    return (c == MDU_DIVU) || (c == MDU_REMU);
  endfunction

endpackage

// File: rtl/cpu_mdu_issue_if.sv
// Handshake bundle between decode, writeback and cpu_mdu.
// slave is the issue block's view; master is the surrounding pipeline.
interface cpu_mdu_issue_if
  import cpu_mdu_issue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_control;
  logic            req_word;
  logic [4:0]      req_rd;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [4:0]      rsp_rd;
  logic [XLEN-1:0] rsp_result;
  logic            busy;
  logic            mdu_start;
  logic [2:0]      mdu_control;
  logic [XLEN-1:0] mdu_operand_a;
  logic [XLEN-1:0] mdu_operand_b;
  logic            mdu_ready;
  logic [XLEN-1:0] mdu_result;

  modport slave (
    input  req_valid, req_control, req_word, req_rd,
    input  req_a, req_b, flush, rsp_ready,
    input  mdu_ready, mdu_result,
    output req_ready, rsp_valid, rsp_rd, rsp_result,
    output busy, mdu_start, mdu_control,
    output mdu_operand_a, mdu_operand_b
  );

  modport master (
    output req_valid, req_control, req_word, req_rd,
    output req_a, req_b, flush, rsp_ready,
    output mdu_ready, mdu_result,
    input  req_ready, rsp_valid, rsp_rd, rsp_result,
    input  busy, mdu_start, mdu_control,
    input  mdu_operand_a, mdu_operand_b
  );

endinterface

// File: rtl/cpu_mdu_issue_wordext_unit.sv
// RV64 *W operand extension and result sign-extension.
// Collapses to pass-through when XLEN is 32.
module wordext_unit
  import cpu_mdu_issue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      control,
  input  logic            word,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            res_word,
  input  logic [XLEN-1:0] res_i,
  output logic            word_eff,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o,
  output logic [XLEN-1:0] res_o
);

  if (XLEN == 64) begin : g_rv64
    logic zext;

    // No MULHW exists, so high-half multiplies fall back to full width.
    assign word_eff = word && !is_mulh(control);
    assign zext     = is_unsigned_div(control);

    always_comb begin
      a_o = a_i;
      b_o = b_i;
      if (word_eff) begin
        a_o = zext ? {32'b0, a_i[31:0]}
                   : {{32{a_i[31]}}, a_i[31:0]};
        b_o = zext ? {32'b0, b_i[31:0]}
                   : {{32{b_i[31]}}, b_i[31:0]};
      end
    end

    assign res_o = res_word ? {{32{res_i[31]}}, res_i[31:0]}
                            : res_i;
  end else begin : g_rv32
    logic unused_word;

    assign unused_word = ^{control, word, res_word};
    assign word_eff    = 1'b0;
    assign a_o         = a_i;
    assign b_o         = b_i;
    assign res_o       = res_i;
  end

endmodule

// File: rtl/cpu_mdu_issue.sv
// Execute-stage requester for cpu_mdu: issue, wait, hold result.
// An in-flight divide cannot be aborted, so flush drains it.
module cpu_mdu_issue
  import cpu_mdu_issue_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input logic           clk,
  input logic           reset,
  cpu_mdu_issue_if.slave io
);

  state_e          state_q, state_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            word_eff;
  logic [XLEN-1:0] ext_a;
  logic [XLEN-1:0] ext_b;
  logic [XLEN-1:0] ext_res;

  wordext_unit #(.XLEN(XLEN)) u_wordext (
    .control  (io.req_control),
    .word     (io.req_word),
    .a_i      (io.req_a),
    .b_i      (io.req_b),
    .res_word (word_q),
    .res_i    (io.mdu_result),
    .word_eff (word_eff),
    .a_o      (ext_a),
    .b_o      (ext_b),
    .res_o    (ext_res)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    word_d  = word_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (io.req_valid && !io.flush) begin
          state_d = BUSY;
          ctrl_d  = io.req_control;
          rd_d    = io.req_rd;
          word_d  = word_eff;
          a_d     = ext_a;
          b_d     = ext_b;
        end
      end
      BUSY: begin
        // Flush wins over a same-edge ready.
        if (io.mdu_ready) begin
          if (io.flush) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
            res_d   = ext_res;
          end
        end else if (io.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (io.mdu_ready) state_d = IDLE;
      end
      DONE: begin
        if (io.rsp_ready || io.flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      rd_q    <= '0;
      word_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      word_q  <= word_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign io.req_ready     = (state_q == IDLE);
  assign io.busy          = (state_q != IDLE);
  assign io.mdu_start     = (state_q == BUSY) || (state_q == DRAIN);
  assign io.rsp_valid     = (state_q == DONE);
  assign io.rsp_rd        = rd_q;
  assign io.rsp_result    = res_q;
  assign io.mdu_control   = ctrl_q;
  assign io.mdu_operand_a = a_q;
  assign io.mdu_operand_b = b_q;

endmodule

// File: tb/tb_cpu_mdu_issue.sv
// Bench for cpu_mdu_issue: XLEN=64 and XLEN=32 instances in lockstep,
// each paired with a behavioural cpu_mdu responder.
module tb_cpu_mdu_issue;

  logic clk;
  logic reset;
  logic        req_valid;
  logic [2:0]  req_control;
  logic        req_word;
  logic [4:0]  req_rd;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        flush;
  logic        rsp_ready;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  cpu_mdu_issue_if #(.XLEN(64)) i64 ();
  cpu_mdu_issue_if #(.XLEN(32)) i32 ();

  assign i64.req_valid   = req_valid;
  assign i64.req_control = req_control;
  assign i64.req_word    = req_word;
  assign i64.req_rd      = req_rd;
  assign i64.req_a       = req_a;
  assign i64.req_b       = req_b;
  assign i64.flush       = flush;
  assign i64.rsp_ready   = rsp_ready;
  assign i32.req_valid   = req_valid;
  assign i32.req_control = req_control;
  assign i32.req_word    = req_word;
  assign i32.req_rd      = req_rd;
  assign i32.req_a       = req_a[31:0];
  assign i32.req_b       = req_b[31:0];
  assign i32.flush       = flush;
  assign i32.rsp_ready   = rsp_ready;

  cpu_mdu_issue #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .io(i64));
  cpu_mdu_issue #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .io(i32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RISC-V M-extension arithmetic ----------------
  function automatic logic [63:0] calc64(input logic [2:0] c,
                                         input logic [63:0] a,
                                         input logic [63:0] b);
    logic [127:0] pa, pb, p;
    pa = {{64{a[63]}}, a};
    pb = {{64{b[63]}}, b};
    if (c == 3'd2) pb = {64'b0, b};
    if (c == 3'd3) begin pa = {64'b0, a}; pb = {64'b0, b}; end
    p = pa * pb;
    case (c)
      3'd0: return p[63:0];
      3'd1, 3'd2, 3'd3: return p[127:64];
      3'd4: begin
        if (b == 0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] calc32(input logic [2:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] pa, pb, p;
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    if (c == 3'd2) pb = {32'b0, b};
    if (c == 3'd3) begin pa = {32'b0, a}; pb = {32'b0, b}; end
    p = pa * pb;
    case (c)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == '1) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == '1) return 0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_word(input logic [2:0] c, input logic w);
    return w && !(c inside {3'd1, 3'd2, 3'd3});
  endfunction

  function automatic logic [63:0] ext_op(input logic [2:0] c,
                                         input logic w,
                                         input logic [63:0] x);
    if (!is_word(c, w)) return x;
    if (c == 3'd5 || c == 3'd7) return {32'b0, x[31:0]};
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic logic [63:0] exp64(input logic [2:0] c,
                                        input logic w,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    r = calc64(c, ext_op(c, w, a), ext_op(c, w, b));
    if (is_word(c, w)) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int lat(input logic [2:0] c,
                             input logic [7:0] a,
                             input logic [7:0] b);
    logic [7:0] h;
    h = a ^ b;
    return c[2] ? 4 + int'(h % 4) : 1 + int'(h % 3);
  endfunction

  // ---------------- cpu_mdu stand-ins ----------------
  logic        r64 = 0, r32 = 0;
  logic [63:0] m64 = 0;
  logic [31:0] m32 = 0;
  int          c64 = 0, c32 = 0;

  assign i64.mdu_ready  = r64;
  assign i64.mdu_result = m64;
  assign i32.mdu_ready  = r32;
  assign i32.mdu_result = m32;

  always @(posedge clk) begin
    if (reset) begin
      r64 <= 0; c64 <= 0;
    end else if (i64.mdu_start && !r64) begin
      if (c64 + 1 >= lat(i64.mdu_control, i64.mdu_operand_a[7:0],
                         i64.mdu_operand_b[7:0])) begin
        r64 <= 1;
        c64 <= 0;
        m64 <= calc64(i64.mdu_control, i64.mdu_operand_a,
                      i64.mdu_operand_b);
      end else begin
        c64 <= c64 + 1;
      end
    end else begin
      r64 <= 0; c64 <= 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      r32 <= 0; c32 <= 0;
    end else if (i32.mdu_start && !r32) begin
      if (c32 + 1 >= lat(i32.mdu_control, i32.mdu_operand_a[7:0],
                         i32.mdu_operand_b[7:0])) begin
        r32 <= 1;
        c32 <= 0;
        m32 <= calc32(i32.mdu_control, i32.mdu_operand_a,
                      i32.mdu_operand_b);
      end else begin
        c32 <= c32 + 1;
      end
    end else begin
      r32 <= 0; c32 <= 0;
    end
  end

  // ---------------- transaction model ----------------
  // One outstanding op: answered once cpu_mdu replies,
  // killed if a flush arrives before the reply.
  bit          have = 0, ans = 0, kill = 0;
  logic [2:0]  e_c = 0;
  logic [4:0]  e_rd = 0;
  logic [63:0] e_a64 = 0, e_b64 = 0, e_r64 = 0;
  logic [31:0] e_a32 = 0, e_b32 = 0, e_r32 = 0;

  always @(posedge clk) begin
    if (reset) begin
      have <= 0; ans <= 0; kill <= 0;
    end else if (!have) begin
      if (req_valid && !flush) begin
        have  <= 1; ans <= 0; kill <= 0;
        e_c   <= req_control;
        e_rd  <= req_rd;
        e_a64 <= ext_op(req_control, req_word, req_a);
        e_b64 <= ext_op(req_control, req_word, req_b);
        e_r64 <= exp64(req_control, req_word, req_a, req_b);
        e_a32 <= req_a[31:0];
        e_b32 <= req_b[31:0];
        e_r32 <= calc32(req_control, req_a[31:0], req_b[31:0]);
      end
    end else if (!ans) begin
      if (i64.mdu_ready) begin
        if (flush || kill) have <= 0;
        else ans <= 1;
      end else if (flush) begin
        kill <= 1;
      end
    end else if (rsp_ready || flush) begin
      have <= 0;
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [63:0] last64 = 0;
  logic [31:0] last32 = 0;
  logic [4:0]  last_rd = 0;
  int          rsp_cycles = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready64", 64'(i64.req_ready), 64'(!have));
      check("req_ready32", 64'(i32.req_ready), 64'(!have));
      check("busy64", 64'(i64.busy), 64'(have));
      check("busy32", 64'(i32.busy), 64'(have));
      check("start64", 64'(i64.mdu_start), 64'(have && !ans));
      check("start32", 64'(i32.mdu_start), 64'(have && !ans));
      check("rsp_valid64", 64'(i64.rsp_valid), 64'(have && ans));
      check("rsp_valid32", 64'(i32.rsp_valid), 64'(have && ans));
      if (have && !ans) begin
        check("ctrl64", 64'(i64.mdu_control), 64'(e_c));
        check("opa64", i64.mdu_operand_a, e_a64);
        check("opb64", i64.mdu_operand_b, e_b64);
        check("opa32", 64'(i32.mdu_operand_a), 64'(e_a32));
        check("opb32", 64'(i32.mdu_operand_b), 64'(e_b32));
      end
      if (have && ans) begin
        check("rsp_rd64", 64'(i64.rsp_rd), 64'(e_rd));
        check("rsp_rd32", 64'(i32.rsp_rd), 64'(e_rd));
        check("result64", i64.rsp_result, e_r64);
        check("result32", 64'(i32.rsp_result), 64'(e_r32));
      end
      if (i64.rsp_valid) begin
        last64     <= i64.rsp_result;
        last32     <= i32.rsp_result;
        last_rd    <= i64.rsp_rd;
        rsp_cycles <= rsp_cycles + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (i64.req_ready) return;
      @(negedge clk);
    end
    check("timeout_idle", 64'(i64.req_ready), 64'd1);
  endtask

  task automatic issue(input logic [2:0] c, input logic w,
                       input logic [4:0] rd, input logic [63:0] a,
                       input logic [63:0] b);
    wait_idle();
    req_valid   = 1;
    req_control = c;
    req_word    = w;
    req_rd      = rd;
    req_a       = a;
    req_b       = b;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int bp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (i64.rsp_valid) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      check("timeout_rsp", 64'(i64.rsp_valid), 64'd1);
      return;
    end
    repeat (bp) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int n0;

  initial begin
    reset = 1; req_valid = 0; req_control = 0; req_word = 0;
    req_rd = 0; req_a = 0; req_b = 0; flush = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    check("rst_start", 64'(i64.mdu_start), 64'd0);
    check("rst_busy", 64'(i64.busy), 64'd0);
    check("rst_rsp_valid", 64'(i64.rsp_valid), 64'd0);
    check("rst_req_ready", 64'(i64.req_ready), 64'd1);
    check("rst_result", i64.rsp_result, 64'd0);
    check("rst_rd", 64'(i64.rsp_rd), 64'd0);
    check("rst_opa", i64.mdu_operand_a, 64'd0);
    check("rst_opb", 64'(i32.mdu_operand_b), 64'd0);
    check("rst_ctrl", 64'(i32.mdu_control), 64'd0);
    chk_en = 1;

    rsp_ready = 1;
    issue(3'd0, 0, 5'd5, 64'd2, 64'd3);
    wait_rsp(0);
    check("lit_mul", last64, 64'd6);
    check("lit_mul_rd", 64'(last_rd), 64'd5);

    issue(3'd3, 0, 5'd6, 64'h0000_0000_FFFF_FFFF, 64'd2);
    wait_rsp(0);
    check("lit_mulhu32", 64'(last32), 64'd1);
    check("lit_mulhu64", last64, 64'd0);

    issue(3'd4, 0, 5'd7, 64'd1, 64'd0);
    wait_rsp(0);
    check("lit_div0_64", last64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lit_div0_32", 64'(last32), 64'h0000_0000_FFFF_FFFF);

    n0 = rsp_cycles;
    issue(3'd7, 0, 5'd9, 64'd100, 64'd7);
    wait_rsp(5);
    check("lit_remu", last64, 64'd2);
    check("lit_bp_cycles", 64'(rsp_cycles - n0), 64'd6);

    n0 = rsp_cycles;
    issue(3'd4, 0, 5'd10, 64'd1000, 64'd3);
    flush = 1;
    @(negedge clk);
    flush = 0;
    wait_idle();
    @(negedge clk);
    check("lit_flush_norsp", 64'(rsp_cycles - n0), 64'd0);
    issue(3'd0, 0, 5'd11, 64'd5, 64'd1);
    wait_rsp(0);
    check("lit_after_flush", last64, 64'd5);

    issue(3'd4, 1, 5'd12, 64'hFFFF_FFFF_8000_0000, '1);
    wait_rsp(0);
    check("lit_divw", last64, 64'hFFFF_FFFF_8000_0000);
    check("lit_divw32", 64'(last32), 64'h0000_0000_8000_0000);

    issue(3'd7, 1, 5'd13, 64'h0000_0001_0000_0007, 64'd3);
    wait_rsp(0);
    check("lit_remuw", last64, 64'd1);

    req_valid = 1; flush = 1;
    @(negedge clk);
    req_valid = 0; flush = 0;
    check("lit_flush_idle", 64'(i64.busy), 64'd0);

    issue(3'd5, 0, 5'd14, 64'd77, 64'd0);
    reset = 1;
    @(negedge clk);
    check("lit_rst_start", 64'(i64.mdu_start), 64'd0);
    check("lit_rst_valid", 64'(i64.rsp_valid), 64'd0);
    check("lit_rst_busy", 64'(i64.busy), 64'd0);
    reset = 0;
    @(negedge clk);

    for (int k = 0; k < 300; k++) begin
      logic [2:0] c;
      logic w;
      logic [4:0] rd;
      logic [63:0] a, b;
      c  = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31));
      a  = pick();
      b  = pick();
      rsp_ready = 1'($urandom_range(0, 1));
      issue(c, w, rd, a, b);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 8)) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        rsp_ready = 1;
        wait_idle();
        rsp_ready = 0;
      end else begin
        wait_rsp($urandom_range(0, 3));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
